// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller
//
// Register-mapped scan controller. Holds per-digit hex values, decimal points
// and a blank mask, and time-shares the 8-bit segment bus across NUM_DIG
// digits. Each digit slot is 16 sub-ticks of PRE_DIV clocks; the digit is lit
// for the first `duty` sub-ticks of its slot.
//
// Build option: define SEG_SCAN_HEX_EN to decode nibbles A-F as hex glyphs;
// without it those nibbles blank the segments (dp is still driven).
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   wr, waddr, wdata   register write strobe, byte address, data
//   rd, raddr, rdata   register read strobe, byte address, registered data
//   seg_pin[7:0]       segments a-g in bits 0-6, dp in bit 7 (active-high)
//   dig_pin[NUM_DIG]   digit enables (active-low)

module seg_scan_ctrl #(
    parameter int          NUM_DIG = 4,
    parameter int          PRE_DIV = 3125,
    parameter logic [31:0] HW_VER  = 32'h02
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr,
    input  logic [31:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic               rd,
    input  logic [31:0]        raddr,
    output logic [31:0]        rdata,
    output logic [7:0]         seg_pin,
    output logic [NUM_DIG-1:0] dig_pin
);

    localparam int PW = $clog2(PRE_DIV);
    localparam int DW = 4 * NUM_DIG;

    localparam logic [31:0] ADDR_VER   = 32'h00;
    localparam logic [31:0] ADDR_CTRL  = 32'h04;
    localparam logic [31:0] ADDR_DATA  = 32'h08;
    localparam logic [31:0] ADDR_DP    = 32'h0C;
    localparam logic [31:0] ADDR_BLANK = 32'h10;
    localparam logic [31:0] ADDR_STAT  = 32'h14;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;

    logic               en_q, en_d;
    logic [3:0]         duty_q, duty_d;
    logic [DW-1:0]      data_q, data_d;
    logic [NUM_DIG-1:0] dp_q, dp_d;
    logic [NUM_DIG-1:0] blank_q, blank_d;

    // Frame-stable copies that actually drive the display.
    logic [DW-1:0]      data_sh_q, data_sh_d;
    logic [NUM_DIG-1:0] dp_sh_q, dp_sh_d;
    logic [NUM_DIG-1:0] blank_sh_q, blank_sh_d;

    logic [PW-1:0]      pre_q, pre_d;
    logic [3:0]         sub_q, sub_d;
    logic [2:0]         dig_q, dig_d;
    logic [15:0]        frame_q, frame_d;

    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         seg_pin_q, seg_pin_d;
    logic [NUM_DIG-1:0] dig_pin_q, dig_pin_d;

    logic               pre_last;
    logic               sub_last;
    logic               dig_last;

    logic [31:0]        rd_val;
    logic [31:0]        data_ext;
    logic [7:0]         dp_ext;
    logic [7:0]         blank_ext;
    logic [7:0]         dig_ext;
    logic [3:0]         cur_nib;
    logic               lit;

    logic               unused_wdata;
    assign unused_wdata = ^wdata;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
`ifdef SEG_SCAN_HEX_EN
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Register writes.
    always_comb begin
        en_d    = en_q;
        duty_d  = duty_q;
        data_d  = data_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (wr) begin
            case (waddr)
                ADDR_CTRL: begin
                    en_d   = wdata[0];
                    duty_d = wdata[7:4];
                end
                ADDR_DATA:  data_d  = wdata[DW-1:0];
                ADDR_DP:    dp_d    = wdata[NUM_DIG-1:0];
                ADDR_BLANK: blank_d = wdata[NUM_DIG-1:0];
                default: ;
            endcase
        end
    end

    // Register reads sample the pre-write values, so a same-cycle write and
    // read of one address returns the old contents.
    always_comb begin
        rd_val = 32'h0;
        case (raddr)
            ADDR_VER:   rd_val = HW_VER;
            ADDR_CTRL:  rd_val = {24'h0, duty_q, 3'b000, en_q};
            ADDR_DATA:  rd_val = 32'(data_q);
            ADDR_DP:    rd_val = 32'(dp_q);
            ADDR_BLANK: rd_val = 32'(blank_q);
            ADDR_STAT:  rd_val = {frame_q, 7'h0, (state_q == SCAN), 5'h0, dig_q};
            default:    rd_val = 32'h0;
        endcase
        rdata_d = rd ? rd_val : rdata_q;
    end

    assign pre_last = (pre_q == PW'(PRE_DIV - 1));
    assign sub_last = (sub_q == 4'hF);
    assign dig_last = (dig_q == 3'(NUM_DIG - 1));

    // Scan state machine and counters.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        sub_d      = sub_q;
        dig_d      = dig_q;
        frame_d    = frame_q;
        data_sh_d  = data_sh_q;
        dp_sh_d    = dp_sh_q;
        blank_sh_d = blank_sh_q;
        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d    = SCAN;
                    pre_d      = '0;
                    sub_d      = 4'h0;
                    dig_d      = 3'h0;
                    data_sh_d  = data_q;
                    dp_sh_d    = dp_q;
                    blank_sh_d = blank_q;
                end
            end
            SCAN: begin
                if (!en_q) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    sub_d   = 4'h0;
                    dig_d   = 3'h0;
                end else if (!pre_last) begin
                    pre_d = pre_q + 1'b1;
                end else begin
                    pre_d = '0;
                    if (!sub_last) begin
                        sub_d = sub_q + 4'h1;
                    end else begin
                        sub_d = 4'h0;
                        if (!dig_last) begin
                            dig_d = dig_q + 3'h1;
                        end else begin
                            // Frame boundary: pick up the latest register
                            // contents so a frame is never shown half-updated.
                            dig_d      = 3'h0;
                            frame_d    = frame_q + 16'h1;
                            data_sh_d  = data_q;
                            dp_sh_d    = dp_q;
                            blank_sh_d = blank_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin drive. Vectors are widened to the 8-digit maximum so the 3-bit
    // digit counter can index them directly for any NUM_DIG.
    always_comb begin
        data_ext  = 32'(data_sh_q);
        dp_ext    = 8'(dp_sh_q);
        blank_ext = 8'(blank_sh_q);
        cur_nib   = data_ext[{dig_q, 2'b00} +: 4];
        // duty is taken live; sub never exceeds 15, so duty=15 still leaves
        // one dark sub-tick per slot.
        lit       = (state_q == SCAN) && (sub_q < duty_q) && !blank_ext[dig_q];
        dig_ext   = 8'hFF;
        seg_pin_d = 8'h00;
        if (lit) begin
            dig_ext[dig_q] = 1'b0;
            seg_pin_d      = {dp_ext[dig_q], seg_decode(cur_nib)};
        end
        dig_pin_d = dig_ext[NUM_DIG-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            duty_q     <= 4'h0;
            data_q     <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            data_sh_q  <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            pre_q      <= '0;
            sub_q      <= 4'h0;
            dig_q      <= 3'h0;
            frame_q    <= 16'h0;
            rdata_q    <= 32'h0;
            seg_pin_q  <= 8'h00;
            dig_pin_q  <= '1;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            duty_q     <= duty_d;
            data_q     <= data_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            data_sh_q  <= data_sh_d;
            dp_sh_q    <= dp_sh_d;
            blank_sh_q <= blank_sh_d;
            pre_q      <= pre_d;
            sub_q      <= sub_d;
            dig_q      <= dig_d;
            frame_q    <= frame_d;
            rdata_q    <= rdata_d;
            seg_pin_q  <= seg_pin_d;
            dig_pin_q  <= dig_pin_d;
        end
    end

    assign rdata   = rdata_q;
    assign seg_pin = seg_pin_q;
    assign dig_pin = dig_pin_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl

module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] waddr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rd = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  seg_pin;
    logic [3:0]  dig_pin;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] exp;
    } dec_vec_t;

    reg_vec_t rv[9];
    dec_vec_t dv[16];
    logic [7:0] base[16];
    logic [7:0] scan_exp[4];
    int low_cnt[4];
    int bad;
    logic [31:0] rv_tmp;

    seg_scan_ctrl #(
        .NUM_DIG(4),
        .PRE_DIV(2),
        .HW_VER (32'h02)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .wr     (wr),
        .waddr  (waddr),
        .wdata  (wdata),
        .rd     (rd),
        .raddr  (raddr),
        .rdata  (rdata),
        .seg_pin(seg_pin),
        .dig_pin(dig_pin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1;
        raddr = a;
        tick();
        rd = 1'b0;
        d = rdata;
    endtask

    // Counts, over n pin samples, how many cycles each digit was enabled;
    // bad counts samples where more than one digit is on, a digit is on
    // outside its slot, or the segments disagree with scan_exp.
    task automatic scan_window(input int n, input bit check_seg);
        for (int i = 0; i < 4; i++) low_cnt[i] = 0;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if ($countones(~dig_pin) > 1) bad++;
            if (dig_pin == 4'hF && seg_pin != 8'h00) bad++;
            for (int i = 0; i < 4; i++) begin
                if (!dig_pin[i]) begin
                    low_cnt[i]++;
                    if (((c / 32) % 4) != i) bad++;
                    if (check_seg && seg_pin !== scan_exp[i]) bad++;
                end
            end
        end
    endtask

    initial begin
        rv[0] = '{"ctrl_mask",   32'h04, 32'hFFFF_FFF0, 32'h04, 32'h0000_00F0};
        rv[1] = '{"data_mask",   32'h08, 32'hFFFF_FFFF, 32'h08, 32'h0000_FFFF};
        rv[2] = '{"dp_mask",     32'h0C, 32'hFFFF_FFFF, 32'h0C, 32'h0000_000F};
        rv[3] = '{"blank_mask",  32'h10, 32'h0000_00AB, 32'h10, 32'h0000_000B};
        rv[4] = '{"ver_ro",      32'h00, 32'h0000_0055, 32'h00, 32'h0000_0002};
        rv[5] = '{"unmapped",    32'h18, 32'h1234_5678, 32'h18, 32'h0000_0000};
        rv[6] = '{"stat_ro",     32'h14, 32'hFFFF_FFFF, 32'h14, 32'h0000_0000};
        rv[7] = '{"data_val",    32'h08, 32'h0000_1234, 32'h08, 32'h0000_1234};
        rv[8] = '{"misaligned",  32'h06, 32'hFFFF_FFFF, 32'h04, 32'h0000_00F0};

        base = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
`ifdef SEG_SCAN_HEX_EN
                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
`else
                 8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        for (int i = 0; i < 16; i++) begin
            dv[i].nib = 4'(i);
            dv[i].dp  = ~i[0];
            dv[i].exp = base[i] | (i[0] ? 8'h00 : 8'h80);
        end
        scan_exp = '{8'h06, 8'h5B, 8'h4F, 8'h66};

        // Reset state.
        tick();
        tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_seg", {24'h0, seg_pin}, 32'h0);
        check("rst_dig", {28'h0, dig_pin}, 32'hF);
        rstn = 1'b1;
        tick();
        rd_reg(32'h00, rv_tmp);
        check("rd_ver", rv_tmp, 32'h0000_0002);
        rd_reg(32'h14, rv_tmp);
        check("rd_stat_rst", rv_tmp, 32'h0);

        // Register map table.
        for (int k = 0; k < 9; k++) begin
            wr_reg(rv[k].waddr, rv[k].wdata);
            rd_reg(rv[k].raddr, rv_tmp);
            check(rv[k].name, rv_tmp, rv[k].exp);
        end

        // Same-cycle write and read returns the old value; rdata then holds.
        wr = 1'b1; waddr = 32'h08; wdata = 32'hAAAA;
        rd = 1'b1; raddr = 32'h08;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("wr_rd_same", rdata, 32'h0000_1234);
        rd_reg(32'h08, rv_tmp);
        check("wr_rd_after", rv_tmp, 32'h0000_AAAA);
        tick(); tick(); tick();
        check("rdata_hold", rdata, 32'h0000_AAAA);

        // Clear everything with a reset pulse.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;

        // Full scan: 4 digits, duty 15, PRE_DIV 2.
        wr_reg(32'h08, 32'h4321);
        wr_reg(32'h04, 32'hF1);
        tick();
        scan_window(128, 1'b1);
        for (int i = 0; i < 4; i++) check($sformatf("scan_low_%0d", i), low_cnt[i], 30);
        check("scan_bad", bad, 0);
        rd_reg(32'h14, rv_tmp);
        check("stat_frame1", rv_tmp, 32'h0001_0100);

        // Mid-frame DATA write is deferred to the next frame.
        wr_reg(32'h04, 32'h0);
        wr_reg(32'h08, 32'h4321);
        wr_reg(32'h04, 32'hF1);
        tick();
        for (int c = 0; c < 140; c++) begin
            if (c == 40) begin
                wr = 1'b1; waddr = 32'h08; wdata = 32'h0;
            end else begin
                wr = 1'b0;
            end
            tick();
            case (c)
                33:  begin check("shadow_d1_seg", seg_pin, 8'h5B); check("shadow_d1_dig", dig_pin, 4'hD); end
                70:  begin check("shadow_d2_seg", seg_pin, 8'h4F); check("shadow_d2_dig", dig_pin, 4'hB); end
                100: begin check("shadow_d3_seg", seg_pin, 8'h66); check("shadow_d3_dig", dig_pin, 4'h7); end
                130: begin check("shadow_new_seg", seg_pin, 8'h3F); check("shadow_new_dig", dig_pin, 4'hE); end
                default: ;
            endcase
        end

        // duty = 0 keeps the display dark.
        wr_reg(32'h04, 32'h01);
        tick();
        scan_window(64, 1'b0);
        check("duty0_on", low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3], 0);

        // BLANK digit 1 with duty 8.
        wr_reg(32'h04, 32'h0);
        wr_reg(32'h10, 32'h2);
        wr_reg(32'h04, 32'h81);
        tick();
        scan_window(128, 1'b0);
        check("blank_d0", low_cnt[0], 16);
        check("blank_d1", low_cnt[1], 0);
        check("blank_d2", low_cnt[2], 16);
        check("blank_d3", low_cnt[3], 16);
        check("blank_bad", bad, 0);
        wr_reg(32'h10, 32'h0);

        // Decode table on digit 0, with dp on even entries.
        for (int i = 0; i < 16; i++) begin
            wr_reg(32'h04, 32'h0);
            wr_reg(32'h08, {28'h0, dv[i].nib});
            wr_reg(32'h0C, {31'h0, dv[i].dp});
            wr_reg(32'h04, 32'hF1);
            tick();
            tick();
            check($sformatf("dec_seg_%0d", i), seg_pin, dv[i].exp);
            check($sformatf("dec_dig_%0d", i), dig_pin, 4'hE);
        end

        // Disable mid-slot.
        wr_reg(32'h04, 32'hF1);
        repeat (5) tick();
        wr_reg(32'h04, 32'h0);
        tick();
        tick();
        check("dis_seg", seg_pin, 8'h00);
        check("dis_dig", dig_pin, 4'hF);
        rd_reg(32'h14, rv_tmp);
        check("dis_stat_scan", {31'h0, rv_tmp[8]}, 32'h0);

        // Asynchronous reset mid-scan.
        wr_reg(32'h04, 32'hF1);
        repeat (10) tick();
        check("pre_rst_dig", dig_pin, 4'hE);
        rd_reg(32'h00, rv_tmp);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_seg", seg_pin, 8'h00);
        check("arst_dig", dig_pin, 4'hF);
        check("arst_rdata", rdata, 32'h0);
        tick();
        rstn = 1'b1;
        for (int a = 1; a < 6; a++) begin
            rd_reg(32'(a * 4), rv_tmp);
            check($sformatf("post_rst_%0d", a), rv_tmp, 32'h0);
        end
        tick();
        check("post_rst_dig", dig_pin, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

CPU-mapped scan controller for a multiplexed common-anode 7-segment display. Holds per-digit hex values, decimal points and blank mask, and time-shares the single 8-bit segment bus between `NUM_DIG` digits with a prescaled scan scheduler and a 16-step brightness duty. Sits on the same simple wr/rd register bus as the other peripheral blocks, and drives the segment and digit pins directly.

## Interface
- `NUM_DIG`, 4: number of digits, 1–8.
- `PRE_DIV`, 3125: clocks per sub-tick, at least 2. One digit slot is 16 sub-ticks.
- `HW_VER`, 32'h02: value returned at the VER register.

- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `wr`  in  1: write strobe.
- `waddr`  in  32: write byte address.
- `wdata`  in  32: write data.
- `rd`  in  1: read strobe.
- `raddr`  in  32: read byte address.
- `rdata`  out  32: read data, registered.
- `seg_pin`  out  8: segment drive, active-high. Bits 0–6 are segments a–g; bit 7 is dp.
- `dig_pin`  out  `NUM_DIG`: digit enables, active-low.

## Operation
- Register map. Writes to RO or unmapped addresses are ignored. Reads of unmapped addresses return 0. All registers reset to 0.
  - 0x00 VER (RO): `HW_VER`.
  - 0x04 CTRL: bit [0] `en`; bits [7:4] `duty`.
  - 0x08 DATA: nibble `[4i+3:4i]` is the value for digit i.
  - 0x0C DP: bit i lights the dp of digit i.
  - 0x10 BLANK: bit i forces digit i dark.
  - 0x14 STAT (RO): bits [2:0] current digit; bit [8] scanning; bits [31:16] frame count.
- Bits above the used fields read back as 0.
- Scan counters:
  - `pre` counts 0..`PRE_DIV`-1.
  - At `pre` terminal, `sub` advances 0..15.
  - At `sub`=15 terminal, `dig` advances 0..`NUM_DIG`-1.
  - When `dig` wraps, the 16-bit frame count increments. It wraps from 0xFFFF to 0.
- State machine:
  - IDLE → SCAN when `en`=1. Entering SCAN clears `pre`, `sub` and `dig`, and loads the shadow registers.
  - SCAN → IDLE when `en`=0, on the next clock. Counters are cleared and the frame count is held.
- Shadowing:
  - DATA, DP and BLANK are copied into shadow registers on SCAN entry and at every frame wrap (`dig` from `NUM_DIG`-1 to 0).
  - Mid-frame writes do not tear the displayed frame.
  - CTRL `duty` is used live.
- Decode: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F. A–F are covered under Configuration. dp is OR-ed into bit 7.
- Drive in SCAN:
  - `dig_pin[dig]` is 0 when `sub` < `duty` and BLANK bit `dig` is clear. All other digit bits are 1.
  - `seg_pin` is the decode of the current digit while lit, else 0.
  - `duty`=0 gives a fully dark display. The maximum on-time is 15/16, so at least one dark sub-tick per slot guards against ghosting.
- Drive in IDLE: `dig_pin` is all 1s and `seg_pin` is 0.
- Simultaneous `wr` and `rd` to the same address: `rdata` returns the pre-write value.

## Timing
- Reset values:
  - `rdata` = 0, `seg_pin` = 0, `dig_pin` = all 1s.
  - State is IDLE and all counters are 0.
- Register write: a write in cycle T is visible in the register after edge T.
- Read latency: `rdata` is valid one cycle after the `rd` cycle. It holds its value while `rd`=0.
- Pin outputs are registered: pins reflect the counter and state values of the previous cycle.
- Enable: CTRL write with `en`=1 at edge T gives SCAN at T+1. With `duty` > 0, `dig_pin[0]` goes low at T+2.
- Disable: CTRL write with `en`=0 at edge T gives IDLE at T+1. Pins are dark at T+2.
- Slot period is 16·`PRE_DIV` clocks. Frame period is 16·`PRE_DIV`·`NUM_DIG` clocks.
- Asynchronous reset mid-scan immediately forces the reset values.

## Configuration
- `SEG_SCAN_HEX_EN` defined: nibbles 0xA–0xF decode to A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- `SEG_SCAN_HEX_EN` undefined: nibbles 0xA–0xF decode to 0x00 (blank segments; dp still honoured).

## Test plan
- Reset, then read 0x00 and 0x14 → `rdata` is 0x00000002, then 0x00000000. `seg_pin`=0x00 and `dig_pin`=4'hF.
- With `PRE_DIV`=2: write DATA=0x4321, CTRL=0xF1 → each digit is low for 30 of 32 clocks. `seg_pin` steps 0x06, 0x5B, 0x4F, 0x66, and STAT frame count reaches 1 after 128 clocks.
- Write DATA=0x0000 while digit 1 is lit → digits 1–3 still show the old values. The new value 0x3F appears from the next frame start.
- Set `duty`=0 → `dig_pin` stays 4'hF. Set BLANK=0x2 with `duty`=8 → digit 1 is never enabled and the other digits are on for 16 of 32 clocks.
- Write DATA=0xE, DP=0x1 → `seg_pin`=0xF9 with `SEG_SCAN_HEX_EN` defined, 0x80 without it.
- Clear `en` mid-slot, then assert `rstn` low mid-scan → pins are dark within 2 clocks, STAT bit 8 reads 0, and after reset all registers read 0.
